lifo_stack_ctrl: RTL

//  LIFO stack controller with an N-bit up/down stack pointer and a register-file store.

---
 rtl/lifo_stack_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/lifo_stack_ctrl.sv
// LIFO stack controller: up/down stack pointer over a register-file store,
// with full/empty decode, sticky overflow/underflow flags and registered pop data.
module lifo_stack_ctrl #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             CLK,
    input  logic             Clr,
    input  logic             PUSH,
    input  logic [WIDTH-1:0] DIN,
    input  logic             POP,
    output logic [WIDTH-1:0] DOUT,
    output logic             DVALID,
    output logic             FULL,
    output logic             EMPTY,
    output logic [AW:0]      COUNT,
    output logic             OVF,
    output logic             UNF,
    input  logic             ERR_CLR
);

    localparam int DEPTH = 2**AW;
    localparam logic [AW:0] SP_FULL = {1'b1, {AW{1'b0}}};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_sp;
    logic [WIDTH-1:0] r_dout;
    logic             r_dvalid;
    logic             r_ovf;
    logic             r_unf;

    logic             w_full;
    logic             w_empty;
    logic [AW-1:0]    w_topIdx;
    logic [AW-1:0]    w_wrIdx;
    logic             w_wrEn;

    assign w_full   = (r_sp == SP_FULL);
    assign w_empty  = (r_sp == '0);
    // At SP == DEPTH the low bits are zero, so the decrement still lands on the top entry.
    assign w_topIdx = r_sp[AW-1:0] - AW'(1);
    assign w_wrIdx  = POP ? w_topIdx : r_sp[AW-1:0];
    assign w_wrEn   = PUSH && ((!POP && !w_full) || (POP && !w_empty));

    always_ff @(posedge CLK) begin
        if (w_wrEn) begin
            r_mem[w_wrIdx] <= DIN;
        end
    end

    // Error clear is issued first so a same-cycle error assignment below overrides it.
    always_ff @(posedge CLK or posedge Clr) begin
        if (Clr) begin
            r_sp     <= '0;
            r_dout   <= '0;
            r_dvalid <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            r_dvalid <= 1'b0;
            if (ERR_CLR) begin
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end
            case ({PUSH, POP})
                2'b10: begin
                    if (!w_full) begin
                        r_sp <= r_sp + (AW+1)'(1);
                    end else begin
                        r_ovf <= 1'b1;
                    end
                end
                2'b01: begin
                    if (!w_empty) begin
                        r_dout   <= r_mem[w_topIdx];
                        r_sp     <= r_sp - (AW+1)'(1);
                        r_dvalid <= 1'b1;
                    end else begin
                        r_unf <= 1'b1;
                    end
                end
                2'b11: begin
                    r_dout   <= w_empty ? DIN : r_mem[w_topIdx];
                    r_dvalid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign DOUT   = r_dout;
    assign DVALID = r_dvalid;
    assign FULL   = w_full;
    assign EMPTY  = w_empty;
    assign COUNT  = r_sp;
    assign OVF    = r_ovf;
    assign UNF    = r_unf;

endmodule
